// File: rtl/spi_wb_sequencer.sv
`timescale 1ns/1ps
// Sequences one SPI transfer per command through a Wishbone-attached SPI master core.
// Latency: 4-5 bus cycles plus polls, each bus access followed by one idle cycle.
// Backpressure: cmd_ready low until the previous response is taken; response held until rsp_ready.
module spi_wb_sequencer #(
  parameter int DIV_W     = 16,
  parameter int MAX_POLLS = 1023,
  parameter int SS_NB     = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_data,
  input  logic [4:0]       cmd_len,
  input  logic [SS_NB-1:0] cmd_ss,
  input  logic [2:0]       cmd_mode,
  input  logic [DIV_W-1:0] cfg_divider,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [4:0]       m_adr_o,
  output logic [31:0]      m_dat_o,
  output logic [3:0]       m_sel_o,
  input  logic [31:0]      m_dat_i,
  input  logic             m_ack_i,
  input  logic             m_err_i
);

  // Poll counter is at least 10 bits but grows if MAX_POLLS needs more.
  localparam int PC_W = ($clog2(MAX_POLLS + 1) > 10) ? $clog2(MAX_POLLS + 1) : 10;

  localparam logic [4:0] ADR_DATA   = 5'h00;
  localparam logic [4:0] ADR_CTRL   = 5'h10;
  localparam logic [4:0] ADR_DIVIDE = 5'h14;
  localparam logic [4:0] ADR_SS     = 5'h18;

  typedef enum logic [2:0] {
    IDLE, WR_DIV, WR_TX, WR_SS, WR_CTRL, POLL, RD_RX, RESP
  } state_t;

  state_t state, state_nxt;
  // 'after' holds the state to enter once the one-cycle bus gap has elapsed.
  state_t after, after_nxt;
  logic   gap, gap_nxt;

  logic [31:0]      data_q;
  logic [4:0]       len_q;
  logic [SS_NB-1:0] ss_q;
  logic [2:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] last_div;
  logic             div_written;
  logic [PC_W-1:0]  poll_cnt;
  logic [PC_W-1:0]  poll_inc;
  logic             poll_timeout;

  logic bus_state;
  logic bus;
  logic accept;
  logic term_ok;
  logic term_err;
  logic go_bit;
  logic [31:0] ctrl_word;

  assign bus_state = (state != IDLE) && (state != RESP);
  // Terminations are only honoured while a strobe is actually out.
  assign bus       = bus_state && !gap;
  assign term_err  = bus && m_err_i;
  assign term_ok   = bus && m_ack_i && !m_err_i;
  assign go_bit    = m_dat_i[8];

  assign rsp_valid = (state == RESP);
  assign cmd_ready = (state == IDLE) && !rsp_valid && !wb_rst_i;
  assign accept    = cmd_valid && cmd_ready;

  assign poll_inc     = (poll_cnt == {PC_W{1'b1}}) ? poll_cnt : poll_cnt + 1'b1;
  assign poll_timeout = (poll_inc >= PC_W'(MAX_POLLS));

  // CTRL: ASS=1, IE=0, {LSB,TX_NEG,RX_NEG}=mode, GO=1, CHAR_LEN={2'b0,len}.
  assign ctrl_word = {18'b0, 1'b1, 1'b0, mode_q, 1'b1, 1'b0, 2'b00, len_q};

  // Next-state logic: every bus access ends with one gap cycle in the same state.
  always_comb begin
    state_nxt = state;
    after_nxt = after;
    gap_nxt   = 1'b0;
    if (gap) begin
      state_nxt = after;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = (!div_written || (cfg_divider != last_div)) ? WR_DIV : WR_TX;
          end
        end
        RESP: begin
          if (rsp_ready) state_nxt = IDLE;
        end
        default: begin
          if (term_err) begin
            gap_nxt   = 1'b1;
            after_nxt = RESP;
          end else if (term_ok) begin
            gap_nxt = 1'b1;
            case (state)
              WR_DIV:  after_nxt = WR_TX;
              WR_TX:   after_nxt = WR_SS;
              WR_SS:   after_nxt = WR_CTRL;
              WR_CTRL: after_nxt = POLL;
              POLL:    after_nxt = !go_bit ? RD_RX : (poll_timeout ? RESP : POLL);
              default: after_nxt = RESP;
            endcase
          end
        end
      endcase
    end
  end

  // Wishbone request decode; all fields are zero outside an active cycle.
  always_comb begin
    m_cyc_o = bus;
    m_stb_o = bus;
    m_we_o  = 1'b0;
    m_adr_o = 5'h00;
    m_dat_o = 32'h0;
    m_sel_o = 4'h0;
    if (bus) begin
      m_sel_o = 4'hF;
      case (state)
        WR_DIV:  begin m_we_o = 1'b1; m_adr_o = ADR_DIVIDE; m_dat_o = 32'(div_q); end
        WR_TX:   begin m_we_o = 1'b1; m_adr_o = ADR_DATA;   m_dat_o = data_q;     end
        WR_SS:   begin m_we_o = 1'b1; m_adr_o = ADR_SS;     m_dat_o = 32'(ss_q);  end
        WR_CTRL: begin m_we_o = 1'b1; m_adr_o = ADR_CTRL;   m_dat_o = ctrl_word;  end
        POLL:    m_adr_o = ADR_CTRL;
        RD_RX:   m_adr_o = ADR_DATA;
        default: m_sel_o = 4'hF;
      endcase
    end
  end

  // State, command latches, divider tracking, poll counter and response registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      after       <= IDLE;
      gap         <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      ss_q        <= '0;
      mode_q      <= '0;
      div_q       <= '0;
      last_div    <= '0;
      div_written <= 1'b0;
      poll_cnt    <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      after <= after_nxt;
      gap   <= gap_nxt;
      if (accept) begin
        data_q   <= cmd_data;
        len_q    <= cmd_len;
        ss_q     <= cmd_ss;
        mode_q   <= cmd_mode;
        div_q    <= cfg_divider;
        poll_cnt <= '0;
      end
      if (term_err) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end else if (term_ok) begin
        case (state)
          WR_DIV: begin
            last_div    <= div_q;
            div_written <= 1'b1;
          end
          POLL: begin
            if (go_bit) begin
              poll_cnt <= poll_inc;
              if (poll_timeout) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
              end
            end
          end
          RD_RX: begin
            rsp_data <= m_dat_i;
            rsp_err  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_wb_sequencer.md
SPI_WB_SEQUENCER -- requirements
Module: spi_wb_sequencer

Interface
REQ-001 Parameters (name, default, meaning): DIV_W, 16, divider width; MAX_POLLS, 1023, CTRL polls allowed before timeout; SS_NB, 8, slave-select width.
REQ-002 Ports (name  direction  width  meaning):
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  reset; synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_data  in  32  TX word
cmd_len  in  5  char length in bits; 0 = 32 bits
cmd_ss  in  SS_NB  slave-select mask
cmd_mode  in  3  {lsb, tx_negedge, rx_negedge}
cfg_divider  in  DIV_W  SCLK divider
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_data  out  32  RX word
rsp_err  out  1  bus error or poll timeout
m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone master strobes to SPI core
m_adr_o  out  5  byte address
m_dat_o  out  32  write data
m_sel_o  out  4  byte selects
m_dat_i  in  32  read data, valid with m_ack_i
m_ack_i, m_err_i  in  1 each  cycle termination

Function
REQ-003 SPI core map (byte address): RX0/TX0 = 0x00, CTRL = 0x10, DIVIDE = 0x14, SS = 0x18; CTRL bits: CHAR_LEN [6:0], GO 8, RX_NEGEDGE 9, TX_NEGEDGE 10, LSB 11, IE 12, ASS 13.
REQ-004 States: IDLE, WR_DIV, WR_TX, WR_SS, WR_CTRL, POLL, RD_RX, RESP.
REQ-005 cmd_ready = 1 only in IDLE with rsp_valid = 0; on accept, latch cmd_data, cmd_len, cmd_ss, cmd_mode and cfg_divider.
REQ-006 From IDLE: go to WR_DIV if latched divider differs from last-written divider or no divider has been written since reset; otherwise go to WR_TX.
REQ-007 Sequence: WR_DIV -> WR_TX -> WR_SS -> WR_CTRL -> POLL -> RD_RX -> RESP -> IDLE.
REQ-008 Each state issues exactly one Wishbone cycle: m_cyc_o = m_stb_o = 1 from the first cycle of the state and held until m_ack_i or m_err_i; m_adr_o, m_we_o, m_dat_o and m_sel_o are stable throughout.
REQ-009 After each termination, m_cyc_o and m_stb_o are 0 for exactly one cycle before the next bus cycle.
REQ-010 Write cycles: m_we_o = 1, m_sel_o = 4'hF.
REQ-011 Write data: WR_DIV writes zero-extended divider; WR_TX writes cmd_data; WR_SS writes zero-extended cmd_ss.
REQ-012 WR_CTRL writes CHAR_LEN = {2'b0, cmd_len}, GO = 1, RX_NEGEDGE/TX_NEGEDGE/LSB from cmd_mode, IE = 0, ASS = 1, all other bits 0.
REQ-013 Read cycles (POLL, RD_RX): m_we_o = 0, m_sel_o = 4'hF, m_dat_o = 0.
REQ-014 POLL reads CTRL; if m_dat_i[8] = 0 on ack go to RD_RX, else increment the poll counter and repeat POLL.
REQ-015 Timeout: when the poll counter reaches MAX_POLLS with GO still 1, go to RESP with rsp_err = 1 and rsp_data = 0.
REQ-016 RD_RX latches m_dat_i into rsp_data on ack, with rsp_err = 0.
REQ-017 m_err_i in any state: abort the sequence and go to RESP with rsp_err = 1, rsp_data = 0; a failed WR_DIV does not update the last-written divider.
REQ-018 RESP: rsp_valid = 1, rsp_data and rsp_err held stable until rsp_ready; then IDLE. Simultaneous rsp_ready and a new cmd_valid: the command is not accepted in that cycle.
REQ-019 Poll counter: 10-bit minimum, saturating, cleared on each command accept.
REQ-020 m_ack_i or m_err_i while m_stb_o = 0 is ignored.

Reset
REQ-021 While wb_rst_i = 1 at a clock edge: state = IDLE; cmd_ready = 0 during reset and 1 the cycle after; rsp_valid = 0; rsp_err = 0; rsp_data = 0; m_cyc_o = m_stb_o = m_we_o = 0; m_adr_o = 0; m_dat_o = 0; m_sel_o = 0; poll counter = 0; divider-written flag cleared.
REQ-022 Reset mid-sequence abandons the bus cycle immediately; no response is produced.

Verification
REQ-023 First command after reset: cmd_data = 0xA5, cmd_len = 8, cmd_ss = 0x01, cfg_divider = 4; slave model returns 0x3C -> bus writes in order 0x14 = 4, 0x00 = 0xA5, 0x18 = 1, 0x10 = 0x2108; polls until GO = 0; reads 0x00; rsp_data = 0x3C, rsp_err = 0.
REQ-024 Second command with the same divider -> no access to 0x14; first access is to 0x00.
REQ-025 Core holds GO = 1 permanently, MAX_POLLS = 4 -> exactly 4 CTRL reads, then rsp_err = 1 and rsp_data = 0.
REQ-026 m_err_i on the WR_SS write -> no CTRL write; rsp_err = 1; next command rewrites the divider only if it was never successfully written.
REQ-027 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready = 0; cmd_len = 0 -> CTRL CHAR_LEN field = 0.
REQ-028 wb_rst_i asserted during POLL -> next cycle m_cyc_o = 0 and rsp_valid = 0; a fresh command re-issues the 0x14 divider write.
